// File: rtl/tqvp_hx2003_pulse_job_scheduler.sv
// tqvp_hx2003_pulse_job_scheduler: job FIFO that sequences the pulse transmitter through queued programs
module tqvp_hx2003_pulse_job_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [30:0]                job_data,
  input  logic                       job_push,
  output logic                       job_full,
  output logic [$clog2(DEPTH):0]     job_level,
  input  logic [GAP_W-1:0]           gap_cycles,
  input  logic                       enable,
  input  logic                       abort,
  input  logic                       overflow_clr,
  output logic [30:0]                tx_cfg,
  output logic                       tx_cfg_load,
  output logic                       tx_start,
  output logic                       tx_stop,
  input  logic                       tx_busy,
  input  logic                       tx_end,
  output logic                       active,
  output logic [7:0]                 jobs_done,
  output logic                       queue_empty_irq,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, RUN, GAP} state_t;
  state_t           state_q;
  logic [30:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic [GAP_W-1:0] gap_q;
  logic [30:0]      cfg_q;
  logic [7:0]       done_q;
  logic             stop_q, irq_q, ovf_q;
  logic             push_ok, pop, fin;
  assign job_full        = level_q == (AW+1)'(DEPTH);
  assign push_ok         = job_push & ~job_full & ~abort;
  assign pop             = state_q == IDLE && enable && level_q != '0 && !abort;
  assign fin             = state_q == RUN && (tx_end || !tx_busy) && !abort;
  assign job_level       = level_q;
  assign tx_cfg          = cfg_q;
  assign tx_cfg_load     = state_q == LOAD;
  assign tx_start        = state_q == START;
  assign tx_stop         = stop_q;
  assign active          = state_q != IDLE;
  assign jobs_done       = done_q;
  assign queue_empty_irq = irq_q;
  assign overflow        = ovf_q;
  // FIFO bookkeeping, job sequencing FSM and status flags; abort overrides everything but reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      gap_q   <= '0;
      cfg_q   <= '0;
      done_q  <= '0;
      stop_q  <= 1'b0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= job_data;
        wr_q        <= wr_q + AW'(1);
      end
      rd_q    <= abort ? wr_q : rd_q + AW'(pop);
      level_q <= abort ? '0 : level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      ovf_q   <= (job_push & job_full & ~abort) | (ovf_q & ~overflow_clr);
      stop_q  <= abort && state_q != IDLE;
      irq_q   <= fin && level_q == '0;
      if (fin) done_q <= done_q + 8'd1;
      if (pop) cfg_q <= mem_q[rd_q];
      if (abort) begin
        state_q <= IDLE;
        gap_q   <= '0;
      end else begin
        case (state_q)
          IDLE:      state_q <= pop ? LOAD : IDLE;
          LOAD:      state_q <= START;
          START:     state_q <= WAIT_BUSY;
          WAIT_BUSY: state_q <= tx_busy ? RUN : WAIT_BUSY;
          RUN: if (fin) begin
            state_q <= gap_cycles != '0 ? GAP : IDLE;
            gap_q   <= gap_cycles != '0 ? gap_cycles - GAP_W'(1) : '0;
          end
          GAP: begin
            state_q <= gap_q == '0 ? IDLE : GAP;
            gap_q   <= gap_q == '0 ? '0 : gap_q - GAP_W'(1);
          end
          default:   state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tqvp_hx2003_pulse_job_scheduler.sv
// tb_tqvp_hx2003_pulse_job_scheduler: directed bench with a simple transmitter model
module tb_tqvp_hx2003_pulse_job_scheduler;
  logic        clk = 0, rst = 1;
  logic [30:0] job_data = '0;
  logic        job_push = 0, enable = 0, abort = 0, overflow_clr = 0, tx_busy = 0, tx_end = 0;
  logic [15:0] gap_cycles = '0;
  logic        job_full, tx_cfg_load, tx_start, tx_stop, active, queue_empty_irq, overflow;
  logic [2:0]  job_level;
  logic [30:0] tx_cfg;
  logic [7:0]  jobs_done;
  int cyc = 0, run_len = 50, busy_at = -1, end_at = -1, end_cyc = -1, idle_gap = -1, load_gap = -1;
  int n_load = 0, n_start = 0, n_stop = 0, n_irq = 0, errs = 0, checks = 0;
  bit pend = 0;
  logic [30:0] log_q[$];

  tqvp_hx2003_pulse_job_scheduler #(.DEPTH(4), .GAP_W(16)) dut (
    .clk(clk), .rst(rst), .job_data(job_data), .job_push(job_push), .job_full(job_full),
    .job_level(job_level), .gap_cycles(gap_cycles), .enable(enable), .abort(abort),
    .overflow_clr(overflow_clr), .tx_cfg(tx_cfg), .tx_cfg_load(tx_cfg_load), .tx_start(tx_start),
    .tx_stop(tx_stop), .tx_busy(tx_busy), .tx_end(tx_end), .active(active), .jobs_done(jobs_done),
    .queue_empty_irq(queue_empty_irq), .overflow(overflow));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // transmitter model (busy 2 cycles after start, end run_len cycles later) and event monitor
  always @(negedge clk) begin
    if (rst || tx_stop) begin busy_at = -1; end_at = -1; end
    tx_busy = busy_at >= 0 && cyc >= busy_at && cyc <= end_at;
    tx_end  = busy_at >= 0 && cyc == end_at;
    if (tx_start) begin busy_at = cyc + 2; end_at = cyc + 2 + run_len; end
    if (tx_cfg_load) begin
      n_load++;
      log_q.push_back(tx_cfg);
      if (end_cyc >= 0) load_gap = cyc - end_cyc;
    end
    n_start += int'(tx_start);
    n_stop  += int'(tx_stop);
    n_irq   += int'(queue_empty_irq);
    if (tx_end) begin end_cyc = cyc; pend = 1; end
    else if (pend && !active) begin idle_gap = cyc - end_cyc; pend = 0; end
  end

  task automatic tick; @(negedge clk); #1; endtask

  task automatic push(input logic [30:0] d);
    job_data = d; job_push = 1; tick; job_push = 0;
  endtask

  task automatic wait_end;
    int n = 0;
    while (tx_end !== 1'b1 && n < 500) begin tick; n++; end
    checks++; if (tx_end !== 1'b1) begin errs++; $display("FAIL wait_end: tx_end=%0b want 1 (timeout)", tx_end); end
  endtask

  task automatic test_reset;
    rst = 1; repeat (3) tick; rst = 0; tick;
    checks++; if (tx_cfg !== 31'h0) begin errs++; $display("FAIL reset_cfg: got %0h want 0", tx_cfg); end
    checks++; if ({tx_cfg_load, tx_start, tx_stop, active, queue_empty_irq, overflow, job_full} !== 7'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 0", {tx_cfg_load, tx_start, tx_stop, active, queue_empty_irq, overflow, job_full}); end
    checks++; if (jobs_done !== 8'd0) begin errs++; $display("FAIL reset_done: got %0d want 0", jobs_done); end
    checks++; if (job_level !== 3'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", job_level); end
  endtask

  task automatic test_single;
    int p;
    gap_cycles = 0; enable = 1; p = cyc;
    push(31'h0000_2100);
    tick;
    checks++; if (tx_cfg_load !== 1'b1) begin errs++; $display("FAIL single_load: got %0b want 1", tx_cfg_load); end
    checks++; if (tx_cfg !== 31'h2100) begin errs++; $display("FAIL single_cfg: got %0h want 2100", tx_cfg); end
    checks++; if (job_level !== 3'd0) begin errs++; $display("FAIL single_level: got %0d want 0", job_level); end
    tick;
    checks++; if ({tx_start, tx_cfg_load} !== 2'b10) begin errs++; $display("FAIL single_start: got %b want 10", {tx_start, tx_cfg_load}); end
    wait_end;
    checks++; if (end_cyc !== p + 55) begin errs++; $display("FAIL single_end_cyc: got %0d want %0d", end_cyc, p + 55); end
    tick;
    checks++; if (jobs_done !== 8'd1) begin errs++; $display("FAIL single_done: got %0d want 1", jobs_done); end
    checks++; if (queue_empty_irq !== 1'b1) begin errs++; $display("FAIL single_irq: got %0b want 1", queue_empty_irq); end
    tick;
    checks++; if ({queue_empty_irq, active} !== 2'b00) begin errs++; $display("FAIL single_after: got %b want 00", {queue_empty_irq, active}); end
  endtask

  task automatic test_gap;
    int i0 = n_irq;
    gap_cycles = 5; enable = 0;
    push(31'h0000_0a05); push(31'h0000_1f10); push(31'h0000_3020);
    enable = 1;
    for (int j = 0; j < 3; j++) begin
      wait_end; tick;
      checks++; if (queue_empty_irq !== (j == 2)) begin errs++; $display("FAIL gap_irq%0d: got %0b want %0b", j, queue_empty_irq, j == 2); end
      repeat (6) tick;
      checks++; if (idle_gap !== 6) begin errs++; $display("FAIL gap_idle%0d: got %0d want 6", j, idle_gap); end
      if (j < 2) begin
        checks++; if (tx_cfg_load !== 1'b1 || load_gap !== 7) begin errs++; $display("FAIL gap_load%0d: load=%0b dist=%0d want 1/7", j, tx_cfg_load, load_gap); end
      end else begin
        checks++; if (active !== 1'b0) begin errs++; $display("FAIL gap_final_idle: active=%0b want 0", active); end
      end
    end
    checks++; if (jobs_done !== 8'd4) begin errs++; $display("FAIL gap_done: got %0d want 4", jobs_done); end
    checks++; if (n_irq - i0 !== 1) begin errs++; $display("FAIL gap_irq_count: got %0d want 1", n_irq - i0); end
  endtask

  task automatic test_overflow;
    logic [30:0] d [4];
    int l0 = log_q.size();
    gap_cycles = 0; enable = 0;
    for (int i = 0; i < 4; i++) begin d[i] = 31'(32'h0011_0101 * (i + 1) + 32'h2000); push(d[i]); end
    checks++; if ({job_full, job_level, overflow} !== {1'b1, 3'd4, 1'b0}) begin
      errs++; $display("FAIL ovf_full: full=%0b level=%0d ovf=%0b want 1/4/0", job_full, job_level, overflow); end
    push(31'h7fff_ffff);
    checks++; if ({overflow, job_level} !== {1'b1, 3'd4}) begin errs++; $display("FAIL ovf_set: ovf=%0b level=%0d want 1/4", overflow, job_level); end
    overflow_clr = 1; push(31'h7fff_fffe); overflow_clr = 0;
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_clr_vs_push: got %0b want 1", overflow); end
    overflow_clr = 1; tick; overflow_clr = 0;
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
    enable = 1;
    for (int i = 0; i < 4; i++) begin wait_end; tick; end
    repeat (10) tick;
    checks++; if (log_q.size() - l0 !== 4) begin errs++; $display("FAIL ovf_jobs_run: got %0d want 4", log_q.size() - l0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (log_q[l0 + i] !== d[i]) begin errs++; $display("FAIL ovf_order%0d: got %0h want %0h", i, log_q[l0 + i], d[i]); end
    end
    checks++; if (jobs_done !== 8'd8) begin errs++; $display("FAIL ovf_done: got %0d want 8", jobs_done); end
  endtask

  task automatic test_abort;
    int n = 0, st, sp, ir;
    enable = 0; gap_cycles = 0;
    push(31'h0000_1111); push(31'h0000_2222);
    enable = 1;
    while (tx_start !== 1'b1 && n < 50) begin tick; n++; end
    repeat (4) tick;
    checks++; if ({active, job_level} !== {1'b1, 3'd1}) begin errs++; $display("FAIL abort_pre: active=%0b level=%0d want 1/1", active, job_level); end
    st = n_start; sp = n_stop; ir = n_irq;
    abort = 1; tick; abort = 0;
    checks++; if ({tx_stop, active, job_level} !== {1'b1, 1'b0, 3'd0}) begin
      errs++; $display("FAIL abort_post: stop=%0b active=%0b level=%0d want 1/0/0", tx_stop, active, job_level); end
    tick;
    checks++; if (tx_stop !== 1'b0) begin errs++; $display("FAIL abort_stop_len: got %0b want 0", tx_stop); end
    repeat (100) tick;
    checks++; if (n_start !== st) begin errs++; $display("FAIL abort_no_start: got %0d want %0d", n_start, st); end
    checks++; if (n_stop !== sp + 1) begin errs++; $display("FAIL abort_stop_count: got %0d want %0d", n_stop, sp + 1); end
    checks++; if (jobs_done !== 8'd8 || n_irq !== ir) begin errs++; $display("FAIL abort_done: done=%0d irqs=%0d want 8/%0d", jobs_done, n_irq, ir); end
  endtask

  task automatic test_simul;
    enable = 1;
    push(31'h0000_3333);
    wait_end;
    abort = 1; tick; abort = 0;
    checks++; if ({jobs_done, tx_stop, queue_empty_irq} !== {8'd8, 1'b1, 1'b0}) begin
      errs++; $display("FAIL abort_end: done=%0d stop=%0b irq=%0b want 8/1/0", jobs_done, tx_stop, queue_empty_irq); end
    abort = 1; push(31'h0000_4321); abort = 0;
    checks++; if ({job_level, overflow} !== {3'd0, 1'b0}) begin errs++; $display("FAIL abort_push: level=%0d ovf=%0b want 0/0", job_level, overflow); end
    repeat (5) tick;
    checks++; if (active !== 1'b0) begin errs++; $display("FAIL abort_push_idle: active=%0b want 0", active); end
  endtask

  task automatic test_reset_gap;
    int sp;
    gap_cycles = 20; enable = 1;
    push(31'h0000_4444);
    wait_end;
    repeat (3) tick;
    checks++; if (active !== 1'b1) begin errs++; $display("FAIL rgap_in_gap: active=%0b want 1", active); end
    sp = n_stop;
    rst = 1; tick;
    checks++; if ({active, tx_stop, jobs_done, tx_cfg, job_level} !== '0) begin
      errs++; $display("FAIL rgap_reset: active=%0b stop=%0b done=%0d cfg=%0h level=%0d want all 0", active, tx_stop, jobs_done, tx_cfg, job_level); end
    rst = 0; tick;
    checks++; if (n_stop !== sp) begin errs++; $display("FAIL rgap_no_stop: got %0d want %0d", n_stop, sp); end
  endtask

  task automatic test_wrap;
    gap_cycles = 0; run_len = 1; enable = 1;
    for (int i = 0; i < 256; i++) begin
      push(31'(i));
      wait_end; tick;
      if (i == 254) begin
        checks++; if (jobs_done !== 8'd255) begin errs++; $display("FAIL wrap_255: got %0d want 255", jobs_done); end
      end
    end
    checks++; if (jobs_done !== 8'd0) begin errs++; $display("FAIL wrap_0: got %0d want 0", jobs_done); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_gap;
    test_overflow;
    test_abort;
    test_simul;
    test_reset_gap;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tqvp_hx2003_pulse_job_scheduler.md
# tqvp_hx2003_pulse_job_scheduler

Job-queue controller that sequences the pulse transmitter through a list of programs without CPU intervention between them. Software pushes job descriptors (program window, loopback and loop count) into a small FIFO. The scheduler loads each job into the transmitter's program configuration, starts it, waits for program end, then inserts a programmable idle gap before the next job. It sits between the TinyQV register interface and the transmitter's reg_1 and run-control fields.

## Interface

Parameters:
- DEPTH, 4: job FIFO entries; must be a power of 2, ≥2.
- GAP_W, 16: width of the inter-job gap counter.

Ports:
- clk  in  1  system clock (64 MHz nominal).
- rst  in  1  reset; synchronous, active-high.
- job_data  in  31  descriptor: [6:0] start_index, [14:8] end_index, [22:15] loop_count, [29:23] loopback_index, [30] loop_forever; bit 7 ignored.
- job_push  in  1  push job_data (1-cycle strobe).
- job_full  out  1  FIFO full.
- job_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- gap_cycles  in  GAP_W  idle cycles inserted after each job.
- enable  in  1  permit starting new jobs.
- abort  in  1  stop the current job and flush the FIFO (1-cycle strobe).
- overflow_clr  in  1  clear the overflow flag.
- tx_cfg  out  31  registered copy of the active descriptor, in the same layout as job_data.
- tx_cfg_load  out  1  1-cycle strobe: transmitter latches tx_cfg.
- tx_start  out  1  1-cycle start strobe (program status bit set).
- tx_stop  out  1  1-cycle stop strobe.
- tx_busy  in  1  transmitter program status bit.
- tx_end  in  1  transmitter program-end event (1-cycle).
- active  out  1  state ≠ IDLE.
- jobs_done  out  8  count of completed jobs; wraps 255→0.
- queue_empty_irq  out  1  1-cycle pulse when a job completes with the FIFO empty.
- overflow  out  1  sticky flag: a push was rejected.

## Operation

- States: IDLE, LOAD, START, WAIT_BUSY, RUN, GAP.
- **IDLE.** If enable=1, the FIFO is non-empty and abort=0, the block pops the head into tx_cfg and moves to LOAD.
- **LOAD.** Asserts tx_cfg_load for one cycle, then moves to START.
- **START.** Asserts tx_start for one cycle, then moves to WAIT_BUSY.
- **WAIT_BUSY.** Moves to RUN on the first cycle with tx_busy=1.
- **RUN.** Waits for tx_end=1, or tx_busy=0 with no tx_end.
  - On that event, jobs_done increments once.
  - queue_empty_irq pulses if job_level=0.
  - Next state is GAP if gap_cycles≠0, otherwise IDLE.
- **GAP.** Lasts exactly gap_cycles cycles (counter loaded with gap_cycles−1 and counts down to 0), then IDLE. gap_cycles is sampled on entry to GAP.
- **enable.** enable=0 never interrupts a running job; it only blocks the IDLE→LOAD transition.
- **abort.** abort=1 in any state:
  - next state is IDLE and the FIFO is flushed (level 0);
  - tx_stop pulses for one cycle if the state was not IDLE;
  - jobs_done does not change.
- **FIFO.**
  - A push is accepted only when job_full=0, regardless of a pop in the same cycle.
  - A rejected push sets overflow.
  - overflow_clr clears overflow; a rejected push in the same cycle wins (overflow stays set).
- **Priorities.**
  - abort beats tx_end in the same cycle: the job is not counted.
  - abort beats job_push in the same cycle: the push is discarded and overflow is not set.
- **tx_cfg.** Holds its value until the next pop.
- **Pointers.** Read/write pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing

- **Reset.** All outputs are 0, state IDLE, FIFO empty, GAP counter 0. Reset during any state returns to IDLE with no tx_stop pulse.
- **Push visibility.** A push at edge E makes job_level/job_full update at E (visible the cycle after the strobe). The earliest IDLE→LOAD decision is the cycle after the push.
- **Job start sequence.**
  - Decision cycle N (IDLE, conditions true).
  - Cycle N+1: LOAD, tx_cfg_load=1, tx_cfg valid, job_level already decremented.
  - Cycle N+2: START, tx_start=1.
  - Cycle N+3: WAIT_BUSY.
- **Job completion.**
  - tx_end sampled in cycle M → jobs_done/queue_empty_irq update at cycle M+1.
  - With gap_cycles=G>0: the state is GAP for cycles M+1…M+G, IDLE at M+G+1.
  - With G=0: IDLE at M+1.
- **Back-to-back throughput.** With G=0 and a non-empty queue, the next tx_cfg_load is at M+2.
- **Strobes.** All strobes are registered (state-decoded) outputs, and each is high for exactly one cycle per event.

## Test plan

- **Single job.** Push 0x0000_2100 (start 0, end 0x21), enable=1, model tx_busy rising 2 cycles after tx_start and tx_end 50 cycles later. Expect:
  - tx_cfg_load 2 cycles after the push;
  - tx_start one cycle later;
  - jobs_done=1 and queue_empty_irq pulse 1 cycle after tx_end.
- **Gap timing.** Push 3 jobs, gap_cycles=5. Expect exactly 5 GAP cycles between each tx_end and the next IDLE, and tx_cfg_load 7 cycles after each tx_end. queue_empty_irq fires only after the 3rd job; jobs_done=3.
- **Overflow.** With DEPTH=4 and enable=0, push 5 jobs. Expect job_full=1 and job_level=4 after 4 pushes, and overflow=1 after the 5th. Release enable: exactly 4 jobs run, in push order. overflow_clr returns overflow to 0.
- **Abort mid-run.** With 2 jobs queued and job 1 in RUN, pulse abort. Expect:
  - tx_stop for 1 cycle;
  - state IDLE;
  - job_level=0;
  - jobs_done unchanged, no queue_empty_irq;
  - no further tx_start.
- **Simultaneous events.**
  - abort with tx_end in the same cycle: jobs_done is not incremented.
  - abort with job_push in the same cycle: level stays 0 and overflow stays 0.
- **Reset and wrap.** Assert rst during GAP: all outputs 0 the next cycle and no tx_stop. Run 256 jobs: jobs_done wraps to 0.
